// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the strobe/busy memory bus: arbiter states,
// address/data widths and the latched request record.
package riscv_mem_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 24;
    localparam int unsigned MEM_DATA_W     = 32;
    localparam int unsigned MEM_MASK_W     = 4;

    typedef enum logic {
        S_ARB  = 1'b0,
        S_WAIT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_MASK_W-1:0] wmask;
        logic                  rstrb;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Strobe/busy memory bus. The requester drives the master side; the memory
// (or the arbiter's upstream ports) implements the slave side.
interface mem_arbiter_if;
    import riscv_mem_pkg::*;

    logic [MEM_DATA_W-1:0] addr;
    logic                  rstrb;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_MASK_W-1:0] wmask;
    logic [MEM_DATA_W-1:0] rdata;
    logic                  rbusy;

    modport master (output addr, rstrb, wdata, wmask, input rdata, rbusy);
    modport slave  (input addr, rstrb, wdata, wmask, output rdata, rbusy);

endinterface

// File: rtl/mem_req_latch.sv
// Per-requester capture: holds the strobed request until it completes
// downstream and keeps the last read data for the requester.
module mem_req_latch
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_rstrb,
    input  logic [MEM_DATA_W-1:0] i_wdata,
    input  logic [MEM_MASK_W-1:0] i_wmask,
    input  logic                  i_done,
    input  logic [MEM_DATA_W-1:0] i_s_rdata,
    output logic                  o_pend,
    output mem_req_t              o_req,
    output logic [MEM_DATA_W-1:0] o_rdata_q
);

    logic                  w_strobe;
    logic                  w_accept;
    logic                  r_pend;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [MEM_DATA_W-1:0] r_wdata;
    logic [MEM_MASK_W-1:0] r_wmask;
    logic                  r_rstrb;
    logic [MEM_DATA_W-1:0] r_rdata_q;

    // A new strobe is legal when idle or in the completion cycle of the previous one.
    assign w_strobe = i_rstrb || (|i_wmask);
    assign w_accept = w_strobe && (!r_pend || i_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wmask   <= '0;
            r_rstrb   <= 1'b0;
            r_rdata_q <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
                r_wmask <= i_wmask;
                r_rstrb <= i_rstrb;
            end
            if (i_done) begin
                r_rdata_q <= i_s_rdata;
            end
            if (w_accept) begin
                r_pend <= 1'b1;
            end else if (i_done) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_pend       = r_pend;
    assign o_req.addr   = MEM_DATA_W'(r_addr);
    assign o_req.wdata  = r_wdata;
    assign o_req.wmask  = r_wmask;
    assign o_req.rstrb  = r_rstrb;
    assign o_rdata_q    = r_rdata_q;

    ap_no_overlap: assert property (@(posedge clk) disable iff (reset)
        !(w_strobe && r_pend && !i_done));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single strobe/busy memory port: latches
// requests, replays the winner downstream and routes completion back.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    mem_arbiter_if.master s
);

    arb_state_e            r_state;
    logic                  r_owner;
    logic                  r_last_grant;
    logic [MEM_DATA_W-1:0] r_s_addr;
    logic [MEM_DATA_W-1:0] r_s_wdata;

    logic                  w_pend0, w_pend1;
    logic                  w_done0, w_done1;
    mem_req_t              w_req0, w_req1, w_sel;
    logic [MEM_DATA_W-1:0] w_rdata_q0, w_rdata_q1;
    logic                  w_grant;
    logic                  w_winner;
    logic [MEM_DATA_W-1:0] w_s_addr;
    logic [MEM_DATA_W-1:0] w_s_wdata;

    mem_req_latch #(.ADDR_WIDTH(ADDR_WIDTH)) u_latch0 (
        .clk       (clk),
        .reset     (reset),
        .i_addr    (m0.addr[ADDR_WIDTH-1:0]),
        .i_rstrb   (m0.rstrb),
        .i_wdata   (m0.wdata),
        .i_wmask   (m0.wmask),
        .i_done    (w_done0),
        .i_s_rdata (s.rdata),
        .o_pend    (w_pend0),
        .o_req     (w_req0),
        .o_rdata_q (w_rdata_q0)
    );

    mem_req_latch #(.ADDR_WIDTH(ADDR_WIDTH)) u_latch1 (
        .clk       (clk),
        .reset     (reset),
        .i_addr    (m1.addr[ADDR_WIDTH-1:0]),
        .i_rstrb   (m1.rstrb),
        .i_wdata   (m1.wdata),
        .i_wmask   (m1.wmask),
        .i_done    (w_done1),
        .i_s_rdata (s.rdata),
        .o_pend    (w_pend1),
        .o_req     (w_req1),
        .o_rdata_q (w_rdata_q1)
    );

    always_comb begin
        w_done0 = (r_state == S_WAIT) && !s.rbusy && !r_owner;
        w_done1 = (r_state == S_WAIT) && !s.rbusy &&  r_owner;
        w_grant = (r_state == S_ARB) && (w_pend0 || w_pend1);
        // On a tie, round-robin hands the bus to the port that did not win last.
        if (w_pend0 && w_pend1) begin
            w_winner = FIXED_PRIO ? 1'b0 : ~r_last_grant;
        end else begin
            w_winner = w_pend1;
        end
        w_sel     = w_winner ? w_req1 : w_req0;
        w_s_addr  = w_grant ? w_sel.addr  : r_s_addr;
        w_s_wdata = w_grant ? w_sel.wdata : r_s_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_ARB;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_s_addr     <= '0;
            r_s_wdata    <= '0;
        end else begin
            r_s_addr  <= w_s_addr;
            r_s_wdata <= w_s_wdata;
            case (r_state)
                S_ARB: begin
                    if (w_grant) begin
                        r_owner      <= w_winner;
                        r_last_grant <= w_winner;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!s.rbusy) begin
                        r_state <= S_ARB;
                    end
                end
                default: r_state <= S_ARB;
            endcase
        end
    end

    assign s.addr   = w_s_addr;
    assign s.wdata  = w_s_wdata;
    assign s.rstrb  = w_grant && w_sel.rstrb;
    assign s.wmask  = w_grant ? w_sel.wmask : '0;

    assign m0.rbusy = w_pend0 && !w_done0;
    assign m1.rbusy = w_pend1 && !w_done1;
    assign m0.rdata = w_done0 ? s.rdata : w_rdata_q0;
    assign m1.rdata = w_done1 ? s.rdata : w_rdata_q1;

endmodule
